// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends start, 8 data bits LSB first, optional parity, stop bit(s).
// Optional even parity bit is compiled in with `define FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             stop_idx;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             par;
`endif

    wire bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            fifo_rd    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            stop_idx   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                        state   <= S_POP;
                    end
                end
                S_POP: begin
                    fifo_rd <= 1'b0;
                    state   <= S_LOAD;
                end
                // FIFO data_out became valid at the edge that closed POP.
                S_LOAD: begin
                    shreg    <= fifo_data;
                    tx       <= 1'b0;
                    cnt      <= '0;
                    idx      <= '0;
                    stop_idx <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                    par      <= ^fifo_data;
`endif
                    state    <= S_START;
                end
                S_START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= shreg[0];
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (idx == 3'd7) begin
                            idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            tx    <= par;
                            state <= S_PARITY;
`else
                            tx    <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                            tx  <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (stop_idx == STOP_LAST) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1 and a small FIFO model feeding it.
// Expectations follow FIFO_UART_TX_PARITY_EN when it is defined for the build.
module tb_fifo_uart_tx;

    logic       clock;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // FIFO model: pushes come from the stimulus, pops on the DUT read strobe.
    logic [7:0] fifo_mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cycles = 0;
    int done_cycles = 0;
    int rd_violations = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .clock      (clock),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clock) begin
        if (fifo_rd) begin
            fifo_data <= fifo_mem[rd_ptr[3:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(negedge clock) begin
        if (fifo_rd) rd_cycles <= rd_cycles + 1;
        if (frame_done) done_cycles <= done_cycles + 1;
        if (fifo_rd && fifo_empty) rd_violations <= rd_violations + 1;
    end

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the start bit, then checks every cycle of the frame against the expected line pattern.
    task automatic check_frame(input logic [7:0] b, input int gap, input int drop_bit,
                               input int rst_bit, input string tag);
        logic bits [0:10];
        int nbits;
        int n;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = b[k];
`ifdef FIFO_UART_TX_PARITY_EN
        bits[9]  = ^b;
        bits[10] = 1'b1;
        nbits    = 11;
`else
        bits[9]  = 1'b1;
        bits[10] = 1'b1;
        nbits    = 10;
`endif
        n = 0;
        while (tx !== 1'b0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_start_gap"}, n, gap);
        if (n >= 50) return;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("%s_tx_bit%0d_c%0d", tag, i, j), tx, bits[i]);
                check($sformatf("%s_busy_bit%0d", tag, i), busy, 1);
                check($sformatf("%s_done_early_bit%0d", tag, i), frame_done, 0);
                if (i == drop_bit && j == 1) enable = 1'b0;
                if (i == rst_bit && j == 1) begin
                    rst = 1'b1;
                    @(negedge clock);
                    check({tag, "_reset_tx"}, tx, 1);
                    check({tag, "_reset_busy"}, busy, 0);
                    check({tag, "_reset_done"}, frame_done, 0);
                    rst = 1'b0;
                    return;
                end
                @(negedge clock);
            end
        end
        check({tag, "_done_pulse"}, frame_done, 1);
        check({tag, "_done_busy"}, busy, 0);
        check({tag, "_done_tx"}, tx, 1);
        @(negedge clock);
        check({tag, "_done_width"}, frame_done, 0);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        push(8'hA5);

        // Reset holds outputs quiet even with enable high and data waiting.
        repeat (4) begin
            @(negedge clock);
            check("reset_tx", tx, 1);
            check("reset_rd", fifo_rd, 0);
            check("reset_busy", busy, 0);
            check("reset_done", frame_done, 0);
        end
        rst = 1'b0;

        check_frame(8'hA5, 3, -1, -1, "a5");
        check("a5_rd_count", rd_cycles, 1);
        check("a5_done_count", done_cycles, 1);

        // Enable high with an empty FIFO must never pop.
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            check("empty_rd", fifo_rd, 0);
            check("empty_tx", tx, 1);
            check("empty_busy", busy, 0);
        end
        check("empty_rd_count", rd_cycles, 1);

        // Back-to-back frames: second start bit 3 cycles after first stop ends.
        push(8'h00);
        push(8'hFF);
        check_frame(8'h00, 3, -1, -1, "b00");
        check_frame(8'hFF, 2, -1, -1, "bff");
        check("b2b_rd_count", rd_cycles, 3);
        check("b2b_done_count", done_cycles, 3);

        // Enable dropped during data bit 3: frame completes, no further pop.
        push(8'h3D);
        push(8'h99);
        check_frame(8'h3D, 3, 4, -1, "drop");
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check("drop_idle_busy", busy, 0);
            check("drop_idle_rd", fifo_rd, 0);
        end
        check("drop_rd_count", rd_cycles, 4);
        check("drop_done_count", done_cycles, 4);

        // Reset during data bit 5 discards the frame without a done pulse.
        enable = 1'b1;
        check_frame(8'h99, 3, -1, 6, "rstmid");
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            check("rstmid_after_done", frame_done, 0);
            check("rstmid_after_tx", tx, 1);
        end
        check("rstmid_rd_count", rd_cycles, 5);
        check("rstmid_done_count", done_cycles, 4);
        check("rd_while_empty", rd_violations, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
